nrzi_rx: RTL and testbench

Toggle-coded serial receiver: the decoding end of the toggle (T-latch style) line coding used across our latch/flip-flop blocks, where a transmitter toggles the line for a `1` bit and holds it for a `0` bit. It samples the line on `enable` strobes and recovers bits as `line xor previous line`. It removes stuffed bits, hunts for a sync byte, and then delivers aligned bytes with a one-cycle valid pulse. It sits between a line/pad sampler and byte-level consumers.

---
 rtl/nrzi_pkg.sv | 14 +
 rtl/nrzi_destuff.sv | 52 +++++
 rtl/nrzi_rx.sv | 115 +++++++++++
 tb/tb_nrzi_rx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/nrzi_pkg.sv
// Shared types and default parameters for the toggle-coded (NRZI) serial receiver.
// The state enum is also what a checker binds to when observing the receive FSM.
package nrzi_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        RECEIVE = 1'b1
    } nrzi_state_t;

    localparam int          DATA_W_DEF    = 8;
    localparam logic [7:0]  SYNC_DEF      = 8'hD5;
    localparam int          STUFF_LEN_DEF = 6;

endpackage : nrzi_pkg

// File: rtl/nrzi_destuff.sv
// Line decoder and bit destuffer: recovers bits as line ^ previous line and
// removes the forced '1' inserted after every STUFF_LEN consecutive zeros.
module nrzi_destuff
    import nrzi_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic line_in,
    output logic rx_bit,
    output logic bit_valid,
    output logic stuff_err
);

    localparam int ZW = $clog2(STUFF_LEN + 1);

    logic          line_prev;
    logic [ZW-1:0] zrun;
    logic [ZW-1:0] zrun_d;
    logic          stuff_slot;

    always_comb begin
        rx_bit     = line_in ^ line_prev;
        stuff_slot = (zrun == ZW'(STUFF_LEN));
        // A stuff slot is never delivered; a '0' there breaks the coding rule.
        bit_valid  = enable && !stuff_slot;
        stuff_err  = enable && stuff_slot && !rx_bit;
        zrun_d     = zrun;
        if (enable) begin
            if (stuff_slot || rx_bit) begin
                zrun_d = '0;
            end else begin
                zrun_d = zrun + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_prev <= 1'b0;
            zrun      <= '0;
        end else begin
            if (enable) begin
                line_prev <= line_in;
            end
            zrun <= zrun_d;
        end
    end

endmodule : nrzi_destuff

// File: rtl/nrzi_rx.sv
// NRZI receiver top: hunts for the sync pattern in the destuffed bit stream,
// then assembles LSB-first bytes back-to-back until a stuffing violation.
module nrzi_rx
    import nrzi_pkg::*;
#(
    parameter int              DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] SYNC    = DATA_W'(SYNC_DEF),
    parameter int              STUFF_LEN = STUFF_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              line_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              sync_lock,
    output logic              error
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic rx_bit;
    logic bit_valid;
    logic stuff_err;

    nrzi_destuff #(
        .STUFF_LEN (STUFF_LEN)
    ) u_destuff (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .line_in   (line_in),
        .rx_bit    (rx_bit),
        .bit_valid (bit_valid),
        .stuff_err (stuff_err)
    );

    nrzi_state_t       state_q, state_d;
    logic [DATA_W-1:0] hunt_sr, hunt_d;
    logic [DATA_W-1:0] rx_sr, rx_d;
    logic [CNT_W-1:0]  bitcnt, cnt_d;
    logic [DATA_W-1:0] data_d;
    logic              valid_d;
    logic              err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            hunt_sr    <= '0;
            rx_sr      <= '0;
            bitcnt     <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hunt_sr    <= hunt_d;
            rx_sr      <= rx_d;
            bitcnt     <= cnt_d;
            data_out   <= data_d;
            data_valid <= valid_d;
            error      <= err_d;
        end
    end

    // sync_lock is the registered state itself, so it needs no separate flop.
    assign sync_lock = (state_q == RECEIVE);

    always_comb begin
        state_d = state_q;
        hunt_d  = hunt_sr;
        rx_d    = rx_sr;
        cnt_d   = bitcnt;
        data_d  = data_out;
        valid_d = 1'b0;
        err_d   = 1'b0;

        if (stuff_err) begin
            // Violation drops any partial byte; only a locked receiver flags it.
            hunt_d = '0;
            if (state_q == RECEIVE) begin
                err_d   = 1'b1;
                state_d = HUNT;
                rx_d    = '0;
                cnt_d   = '0;
            end
        end else if (bit_valid) begin
            case (state_q)
                HUNT: begin
                    hunt_d = {rx_bit, hunt_sr[DATA_W-1:1]};
                    if (hunt_d == SYNC) begin
                        state_d = RECEIVE;
                        rx_d    = '0;
                        cnt_d   = '0;
                    end
                end
                RECEIVE: begin
                    rx_d = {rx_bit, rx_sr[DATA_W-1:1]};
                    if (bitcnt == LAST_BIT) begin
                        data_d  = rx_d;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = bitcnt + 1'b1;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

endmodule : nrzi_rx

// File: tb/tb_nrzi_rx.sv
// Directed bench for nrzi_rx: a toggle-coding transmitter model with stuffing
// drives the line, and expected bytes flow through a scoreboard queue.
module tb_nrzi_rx;

    localparam int         DATA_W    = 8;
    localparam logic [7:0] SYNC      = 8'hD5;
    localparam int         STUFF_LEN = 6;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              line_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              sync_lock;
    logic              error;

    nrzi_rx #(
        .DATA_W    (DATA_W),
        .SYNC      (SYNC),
        .STUFF_LEN (STUFF_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .line_in    (line_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .sync_lock  (sync_lock),
        .error      (error)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_data;
    logic              exp_lock;
    int                n_asserts;
    int                n_fail;

    // transmitter model
    logic              tx_line;
    int                tx_zrun;
    int                en_cnt;
    int                last_v_en;
    logic              spacing_on;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, let the edge happen, check outputs 1 ns later.
    task automatic cycle(input logic en, input logic lvl, input logic exp_v, input logic exp_e);
        enable  = en;
        line_in = lvl;
        @(posedge clk);
        #1;
        if (en) en_cnt++;
        chk("data_valid", {31'b0, data_valid}, {31'b0, exp_v});
        chk("error", {31'b0, error}, {31'b0, exp_e});
        chk("sync_lock", {31'b0, sync_lock}, {31'b0, exp_lock});
        if (exp_v) begin
            if (exp_q.size() == 0) begin
                n_asserts++;
                n_fail++;
                $error("FAIL exp_q: observed empty queue expected a pending byte");
            end else begin
                exp_data = exp_q.pop_front();
            end
            if (spacing_on && last_v_en != 0)
                chk("valid_spacing", en_cnt - last_v_en, 32'd8);
        end
        if (data_valid) last_v_en = en_cnt;
        chk("data_out", {24'b0, data_out}, {24'b0, exp_data});
        enable = 1'b0;
    endtask

    task automatic gaps(input int n);
        repeat (n) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    // Toggle-encode one data bit, inserting a stuffed '1' after STUFF_LEN zeros.
    task automatic send_data_bit(input logic b, input logic exp_v, input int gap);
        if (b) tx_line = ~tx_line;
        cycle(1'b1, tx_line, exp_v, 1'b0);
        gaps(gap);
        tx_zrun = b ? 0 : tx_zrun + 1;
        if (tx_zrun == STUFF_LEN) begin
            tx_line = ~tx_line;
            cycle(1'b1, tx_line, 1'b0, 1'b0);
            gaps(gap);
            tx_zrun = 0;
        end
    endtask

    task automatic send_sync();
        logic [7:0] s;
        s = SYNC;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == DATA_W - 1) exp_lock = 1'b1;
            send_data_bit(s[i], 1'b0, 0);
        end
    endtask

    task automatic send_byte(input logic [DATA_W-1:0] b, input int gap);
        exp_q.push_back(b);
        for (int i = 0; i < DATA_W; i++)
            send_data_bit(b[i], (i == DATA_W - 1), gap);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data_out"}, {24'b0, data_out}, 32'h0);
        chk({tag, "_data_valid"}, {31'b0, data_valid}, 32'h0);
        chk({tag, "_sync_lock"}, {31'b0, sync_lock}, 32'h0);
        chk({tag, "_error"}, {31'b0, error}, 32'h0);
    endtask

    task automatic model_reset();
        tx_line  = 1'b0;
        tx_zrun  = 0;
        exp_lock = 1'b0;
        exp_data = '0;
        exp_q.delete();
    endtask

    initial begin
        n_asserts  = 0;
        n_fail     = 0;
        en_cnt     = 0;
        last_v_en  = 0;
        spacing_on = 1'b0;
        model_reset();
        rst_n   = 1'b0;
        enable  = 1'b0;
        line_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Sync then data: line levels 1,1,0,0,1,1,0,1 form the sync byte.
        send_sync();
        send_byte(8'hA5, 0);

        // Stuffing: 0x00 carries a stuffed '1' after six zeros.
        send_byte(8'h00, 0);
        send_byte(8'h81, 0);

        // Stuff violation: seven zeros from a byte boundary with zrun = 0.
        for (int i = 0; i < 7; i++) begin
            if (i == 6) exp_lock = 1'b0;
            tx_line = tx_line;
            cycle(1'b1, tx_line, 1'b0, (i == 6));
        end
        tx_zrun = 0;
        send_sync();
        send_byte(8'h3C, 0);

        // Enable gaps: three idle cycles after every line bit.
        send_byte(8'h5A, 3);

        // Reset mid-byte after four data bits of 0x77.
        for (int i = 0; i < 4; i++) send_data_bit(1'(8'h77 >> i), 1'b0, 0);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        check_reset_outputs("held_reset");
        rst_n = 1'b1;
        send_sync();
        send_byte(8'h81, 0);

        // Back-to-back bytes after one sync, enable held high.
        spacing_on = 1'b1;
        last_v_en  = 0;
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        spacing_on = 1'b0;
        gaps(4);

        chk("exp_q_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_nrzi_rx
